// File: rtl/raster_int_if.sv
// raster_int_if
//   Bundle of the signals exchanged between the raster interrupt generator
//   and its surroundings (video timing, raster register block, Z80 bus).
//   master : drives timing/config/CPU strobes, receives /INT and status
//   slave  : the interrupt generator itself
//
//   clken                   one-clk CPU T-state enable pulse
//   hc, vc                  horizontal / vertical video counters (9 bit)
//   rasterint_enable        raster interrupt enable
//   vretraceint_disable     1 = suppress the frame interrupt
//   raster_line             programmed raster line (9 bit)
//   m1_n, iorq_n            CPU strobes, only used with INTACK_CLEAR_EN
//   int_n                   registered /INT to the CPU, active-low
//   raster_int_in_progress  high while the current pulse is a raster interrupt
interface raster_int_if;
    logic       clken;
    logic [8:0] hc;
    logic [8:0] vc;
    logic       rasterint_enable;
    logic       vretraceint_disable;
    logic [8:0] raster_line;
    logic       m1_n;
    logic       iorq_n;
    logic       int_n;
    logic       raster_int_in_progress;

    modport master (
        output clken, hc, vc, rasterint_enable, vretraceint_disable,
               raster_line, m1_n, iorq_n,
        input  int_n, raster_int_in_progress
    );

    modport slave (
        input  clken, hc, vc, rasterint_enable, vretraceint_disable,
               raster_line, m1_n, iorq_n,
        output int_n, raster_int_in_progress
    );
endinterface

// File: rtl/raster_int_gen.sv
// raster_int_gen
//   Merges the ULA frame (vertical retrace) interrupt and the programmable
//   raster-line interrupt into a single timed Z80 /INT pulse.
//
//   Ports:
//     clk  master clock
//     rst  synchronous reset, active-high
//     bus  raster_int_if.slave: clken, hc, vc, rasterint_enable,
//          vretraceint_disable, raster_line, m1_n, iorq_n in;
//          int_n, raster_int_in_progress out (both registered)
//
//   Optional feature macro: INTACK_CLEAR_EN
//     defined   : a rising edge of the interrupt acknowledge cycle
//                 (!m1_n && !iorq_n) ends the pulse early
//     undefined : m1_n / iorq_n ignored, pulse is always INT_LEN T-states
module raster_int_gen #(
    parameter int VINT_LINE = 248,
    parameter int VINT_HC   = 0,
    parameter int RINT_HC   = 256,
    parameter int VTOTAL    = 312,
    parameter int INT_LEN   = 32
) (
    input  logic         clk,
    input  logic         rst,
    raster_int_if.slave  bus
);

    localparam logic [8:0] VINT_LINE_C = 9'(VINT_LINE);
    localparam logic [8:0] VINT_HC_C   = 9'(VINT_HC);
    localparam logic [8:0] RINT_HC_C   = 9'(RINT_HC);
    // one bit wider so a VTOTAL of 512 still compares correctly
    localparam logic [9:0] VTOTAL_C    = 10'(VTOTAL);
    localparam logic [5:0] CNT_LAST    = 6'(INT_LEN - 1);

    typedef enum logic {
        IDLE,
        PULSE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       int_n_q, int_n_d;
    logic       rip_q, rip_d;

    logic fmatch, rmatch;
    logic fmatch_q, rmatch_q;
    logic ftrig, rtrig;
    logic ack_clear;

    // Match terms are levels; hc may sit on one value for several clks,
    // so only the rising edge of each term is treated as a trigger.
    always_comb begin
        fmatch = (bus.vc == VINT_LINE_C) && (bus.hc == VINT_HC_C) &&
                 !bus.vretraceint_disable;
        rmatch = bus.rasterint_enable &&
                 ({1'b0, bus.raster_line} < VTOTAL_C) &&
                 (bus.vc == bus.raster_line) && (bus.hc == RINT_HC_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fmatch_q <= 1'b0;
            rmatch_q <= 1'b0;
        end else begin
            fmatch_q <= fmatch;
            rmatch_q <= rmatch;
        end
    end

    assign ftrig = fmatch && !fmatch_q;
    assign rtrig = rmatch && !rmatch_q;

`ifdef INTACK_CLEAR_EN
    logic ack, ack_q;

    assign ack = !bus.m1_n && !bus.iorq_n;

    always_ff @(posedge clk) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= ack;
    end

    // acknowledge edge only matters while a pulse is being driven
    assign ack_clear = ack && !ack_q;
`else
    logic unused_ack;
    assign unused_ack = bus.m1_n & bus.iorq_n;
    assign ack_clear  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_n_d = int_n_q;
        rip_d   = rip_q;
        unique case (state_q)
            IDLE: begin
                if (ftrig || rtrig) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                    int_n_d = 1'b0;
                    // coincident triggers report as a raster interrupt
                    rip_d   = rtrig;
                end
            end
            PULSE: begin
                // triggers arriving here are intentionally dropped
                if (ack_clear) begin
                    state_d = IDLE;
                    int_n_d = 1'b1;
                    rip_d   = 1'b0;
                end else if (bus.clken) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        int_n_d = 1'b1;
                        rip_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                int_n_d = 1'b1;
                rip_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            int_n_q <= 1'b1;
            rip_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_n_q <= int_n_d;
            rip_q   <= rip_d;
        end
    end

    assign bus.int_n                  = int_n_q;
    assign bus.raster_int_in_progress = rip_q;

endmodule

// File: tb/tb_raster_int_gen.sv
module tb_raster_int_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       clken;
    logic [8:0] hc, vc, raster_line;
    logic       rasterint_enable, vretraceint_disable, m1_n, iorq_n;
    logic       sel;       // 0: default instance, 1: RINT_HC=0 instance
    logic       int_n_m, rip_m;
    int         checks = 0;
    int         failures = 0;
    logic [1:0] div;

`ifdef INTACK_CLEAR_EN
    localparam int ACK_LEN = 5;
`else
    localparam int ACK_LEN = 32;
`endif

    raster_int_if if0 ();
    raster_int_if if1 ();

    assign if0.clken = clken;               assign if1.clken = clken;
    assign if0.hc = hc;                     assign if1.hc = hc;
    assign if0.vc = vc;                     assign if1.vc = vc;
    assign if0.raster_line = raster_line;   assign if1.raster_line = raster_line;
    assign if0.rasterint_enable = rasterint_enable;
    assign if1.rasterint_enable = rasterint_enable;
    assign if0.vretraceint_disable = vretraceint_disable;
    assign if1.vretraceint_disable = vretraceint_disable;
    assign if0.m1_n = m1_n;                 assign if1.m1_n = m1_n;
    assign if0.iorq_n = iorq_n;             assign if1.iorq_n = iorq_n;

    assign int_n_m = sel ? if1.int_n : if0.int_n;
    assign rip_m   = sel ? if1.raster_int_in_progress : if0.raster_int_in_progress;

    raster_int_gen dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    raster_int_gen #(.RINT_HC(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    // clken: one clk high every 4 clks
    initial begin
        div = 2'd0;
        clken = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = div + 2'd1;
            clken = (div == 2'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_gap(input int n);
        hc = 9'd1;
        repeat (n) @(negedge clk);
    endtask

    // No pulse may appear for n clks.
    task automatic quiet(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (int_n_m !== 1'b1) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    // Called at a negedge right after the triggering stimulus was driven.
    // Counts the clken pulses the DUT consumes while /INT is low.
    // act (applied once clken count reaches act_at):
    //   1 fresh rmatch edge, 2 reset, 3 intack, 4 clear enables
    task automatic measure(input string tag, input logic exp_rip, input int exp_len,
                           input int act, input int act_at);
        int   n = 0;
        int   guard = 0;
        int   phase = 0;
        logic rip_ok = 1'b1;
        #1;
        check({tag, "_nocomb"}, int_n_m, 1);
        @(negedge clk);
        check({tag, "_latency"}, int_n_m, 0);
        while (int_n_m === 1'b0 && guard < 400) begin
            if (rip_m !== exp_rip) rip_ok = 1'b0;
            if (clken === 1'b1) n++;
            if (phase == 1) begin
                hc = 9'd256;
                phase = 2;
            end else if (phase == 0 && act != 0 && n == act_at) begin
                case (act)
                    1: begin hc = 9'd1; phase = 1; end
                    2: begin rst = 1'b1; hc = 9'd1; phase = 2; end
                    3: begin m1_n = 1'b0; iorq_n = 1'b0; phase = 2; end
                    default: begin
                        rasterint_enable = 1'b0;
                        vretraceint_disable = 1'b1;
                        phase = 2;
                    end
                endcase
            end
            guard++;
            @(negedge clk);
        end
        check({tag, "_len"}, n, exp_len);
        check({tag, "_rip_during"}, rip_ok, 1);
        check({tag, "_rip_after"}, rip_m, 0);
        check({tag, "_int_after"}, int_n_m, 1);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        hc = 9'd1;
        vc = 9'd0;
        raster_line = 9'd0;
        rasterint_enable = 1'b0;
        vretraceint_disable = 1'b0;
        m1_n = 1'b1;
        iorq_n = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_int_n", if0.int_n, 1);
        check("reset_rip", if0.raster_int_in_progress, 0);
        rst = 1'b0;
        idle_gap(5);

        // frame interrupt, match held for the whole pulse: exactly one pulse
        vc = 9'd248; hc = 9'd0;
        measure("frame", 1'b0, 32, 0, 0);
        quiet("frame_held_once", 20);
        idle_gap(150);

        // frame interrupt suppressed
        vretraceint_disable = 1'b1;
        vc = 9'd248; hc = 9'd0;
        quiet("vret_disabled", 20);
        vretraceint_disable = 1'b0;
        idle_gap(5);

        // raster interrupt
        rasterint_enable = 1'b1;
        raster_line = 9'd100;
        vc = 9'd100; hc = 9'd256;
        measure("raster", 1'b1, 32, 0, 0);
        quiet("raster_held_once", 20);
        idle_gap(5);

        // fresh rmatch edge mid-pulse is dropped
        hc = 9'd256;
        measure("retrig", 1'b1, 32, 1, 8);
        quiet("retrig_no_second", 30);
        idle_gap(5);

        // clearing enables mid-pulse does not shorten it
        hc = 9'd256;
        measure("clear_en", 1'b1, 32, 4, 5);
        idle_gap(5);
        rasterint_enable = 1'b1;
        vretraceint_disable = 1'b0;

        // raster_line >= VTOTAL never matches over a full frame (and vc=400)
        vretraceint_disable = 1'b1;
        raster_line = 9'd400;
        begin
            logic seen = 1'b0;
            for (int v = 0; v < 313; v++) begin
                vc = (v == 312) ? 9'd400 : 9'(v);
                hc = 9'd256;
                @(negedge clk);
                if (if0.int_n !== 1'b1 || if1.int_n !== 1'b1) seen = 1'b1;
                hc = 9'd0;
                @(negedge clk);
                if (if0.int_n !== 1'b1 || if1.int_n !== 1'b1) seen = 1'b1;
            end
            check("line400_no_pulse", seen, 0);
        end
        vretraceint_disable = 1'b0;
        idle_gap(5);

        // coincident frame + raster trigger (RINT_HC=0 instance)
        sel = 1'b1;
        raster_line = 9'd248;
        vc = 9'd248; hc = 9'd0;
        measure("coincide", 1'b1, 32, 0, 0);
        sel = 1'b0;
        idle_gap(150);

        // reset mid-pulse, then a full pulse on the next frame trigger
        rasterint_enable = 1'b0;
        vc = 9'd248; hc = 9'd0;
        measure("rst_mid", 1'b0, 10, 2, 10);
        rst = 1'b0;
        idle_gap(5);
        hc = 9'd0;
        measure("after_rst", 1'b0, 32, 0, 0);
        idle_gap(5);

        // interrupt acknowledge mid-pulse
        hc = 9'd0;
        measure("intack", 1'b0, ACK_LEN, 3, 5);
        m1_n = 1'b1;
        iorq_n = 1'b1;
        idle_gap(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
